debug_unit: RTL and testbench

Host-side control stage upstream of the pipelined datapath. It consumes bytes from a UART receiver, loads programs into instruction memory, and gates the pipeline clock-enable for continuous or single-step execution. After each run or step it streams PC, cycle count and the register bank back through a UART transmitter.

---
 rtl/debug_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_debug_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: host-side control stage in front of the pipelined datapath.
// It decodes UART command bytes. 'L' loads a program into instruction memory.
// 'C' runs the pipeline until halt, and 'S' single-steps it. After every run
// or step it streams the PC, the cycle count and the register bank back out
// through the UART transmitter.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid received byte + one-cycle strobe
//   o_tx_data/o_tx_start byte to send + one-cycle request; data held until i_tx_done
//   i_tx_done            transmitter finished the current byte
//   o_im_we/addr/data    instruction memory write port
//   o_cpu_en, o_cpu_rst  pipeline advance enable, one-cycle reset after a load
//   i_halt, i_pc         halt reached WB, current PC
//   o_dbg_reg_addr       register bank debug read index
//   i_dbg_reg_data       combinational register read data
//
// Optional feature macro: DBG_CHECKSUM_EN. When it is defined, the block sends
// the XOR of all loaded data bytes once the load finishes, and then pulses
// o_cpu_rst.
module debug_unit #(
    parameter int NBITS     = 32,
    parameter int RBITS     = 5,
    parameter int BANK_SIZE = 32,
    parameter int MEM_SIZE  = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_im_we,
    output logic [NBITS-1:0] o_im_addr,
    output logic [NBITS-1:0] o_im_data,
    output logic             o_cpu_en,
    output logic             o_cpu_rst,
    input  logic             i_halt,
    input  logic [NBITS-1:0] i_pc,
    output logic [RBITS-1:0] o_dbg_reg_addr,
    input  logic [NBITS-1:0] i_dbg_reg_data
);
    localparam int NBYTES = NBITS / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WW     = $clog2(BANK_SIZE + 2);
    localparam logic [BW-1:0]    LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [WW-1:0]    LAST_WORD = WW'(BANK_SIZE + 1);
    localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(MEM_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_LEN_HI, LOAD_LEN_LO, LOAD_DATA, LOAD_DONE, CSUM_WAIT,
        RUN, STEP, DUMP_SEL, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t           state_q;
    logic [15:0]      len_q;      // words still to load
    logic [BW-1:0]    byte_q;     // byte index within the current word
    logic [NBITS-1:0] word_q;     // load assembly / dump shift register
    logic [NBITS-1:0] addr_q;     // load address
    logic [NBITS-1:0] cyc_q;      // enabled-cycle counter
    logic [WW-1:0]    widx_q;     // dump word index: 0=PC, 1=count, 2..=regs
    logic [7:0]       tx_data_q;
    logic             tx_start_q, im_we_q, cpu_en_q, cpu_rst_q;
    logic [NBITS-1:0] im_addr_q, im_data_q;
    logic [RBITS-1:0] reg_addr_q;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic [NBITS-1:0] word_d, addr_d;
    assign word_d = {word_q[NBITS-9:0], i_rx_data};
    assign addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + NBITS'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            cyc_q      <= '0;
            widx_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_data_q  <= '0;
            cpu_en_q   <= 1'b0;
            cpu_rst_q  <= 1'b0;
            reg_addr_q <= '0;
`ifdef DBG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // Strobes default low so that each one lasts a single cycle.
            im_we_q    <= 1'b0;
            tx_start_q <= 1'b0;
            cpu_en_q   <= 1'b0;
            cpu_rst_q  <= 1'b0;
            case (state_q)
                IDLE: if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C: begin
                            state_q <= LOAD_LEN_HI;
                            cyc_q   <= '0;
                            addr_q  <= '0;
`ifdef DBG_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end
                        8'h43:   state_q <= RUN;
                        8'h53:   state_q <= STEP;
                        default: ;
                    endcase
                end
                LOAD_LEN_HI: if (i_rx_valid) begin
                    len_q   <= {i_rx_data, 8'h00};
                    state_q <= LOAD_LEN_LO;
                end
                LOAD_LEN_LO: if (i_rx_valid) begin
                    len_q   <= {len_q[15:8], i_rx_data};
                    byte_q  <= '0;
                    state_q <= ({len_q[15:8], i_rx_data} == 16'd0) ? LOAD_DONE : LOAD_DATA;
                end
                LOAD_DATA: if (i_rx_valid) begin
                    word_q <= word_d;
`ifdef DBG_CHECKSUM_EN
                    csum_q <= csum_q ^ i_rx_data;
`endif
                    if (byte_q == LAST_BYTE) begin
                        im_we_q   <= 1'b1;
                        im_addr_q <= addr_q;
                        im_data_q <= word_d;
                        addr_q    <= addr_d;
                        len_q     <= len_q - 16'd1;
                        byte_q    <= '0;
                        if (len_q == 16'd1) state_q <= LOAD_DONE;
                    end else begin
                        byte_q <= byte_q + BW'(1);
                    end
                end
`ifdef DBG_CHECKSUM_EN
                LOAD_DONE: begin
                    tx_data_q  <= csum_q;
                    tx_start_q <= 1'b1;
                    state_q    <= CSUM_WAIT;
                end
                CSUM_WAIT: if (i_tx_done) begin
                    cpu_rst_q <= 1'b1;
                    state_q   <= IDLE;
                end
`else
                LOAD_DONE: begin
                    cpu_rst_q <= 1'b1;
                    state_q   <= IDLE;
                end
`endif
                RUN: begin
                    if (i_halt) begin
                        widx_q     <= '0;
                        reg_addr_q <= '0;
                        state_q    <= DUMP_SEL;
                    end else begin
                        cpu_en_q <= 1'b1;
                        cyc_q    <= cyc_q + NBITS'(1);
                    end
                end
                STEP: begin
                    if (!i_halt) begin
                        cpu_en_q <= 1'b1;
                        cyc_q    <= cyc_q + NBITS'(1);
                    end
                    widx_q     <= '0;
                    reg_addr_q <= '0;
                    state_q    <= DUMP_SEL;
                end
                // A step's enable cycle overlaps the first DUMP_SEL cycle.
                // Hold off until it retires, so the sampled PC is the post-step PC.
                DUMP_SEL: if (!cpu_en_q) begin
                    if (widx_q == '0)       word_q <= i_pc;
                    else if (widx_q == WW'(1)) word_q <= cyc_q;
                    else                    word_q <= i_dbg_reg_data;
                    byte_q  <= '0;
                    state_q <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    tx_data_q  <= word_q[NBITS-1 -: 8];
                    tx_start_q <= 1'b1;
                    word_q     <= word_q << 8;
                    state_q    <= DUMP_WAIT;
                end
                DUMP_WAIT: if (i_tx_done) begin
                    if (byte_q == LAST_BYTE) begin
                        if (widx_q == LAST_WORD) begin
                            state_q <= IDLE;
                        end else begin
                            // The next word is widx+1. Its register index is widx-1.
                            if (widx_q != '0) reg_addr_q <= RBITS'(widx_q - WW'(1));
                            widx_q  <= widx_q + WW'(1);
                            state_q <= DUMP_SEL;
                        end
                    end else begin
                        byte_q  <= byte_q + BW'(1);
                        state_q <= DUMP_SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_data      = tx_data_q;
    assign o_tx_start     = tx_start_q;
    assign o_im_we        = im_we_q;
    assign o_im_addr      = im_addr_q;
    assign o_im_data      = im_data_q;
    assign o_cpu_en       = cpu_en_q;
    assign o_cpu_rst      = cpu_rst_q;
    assign o_dbg_reg_addr = reg_addr_q;

endmodule

// File: tb/tb_debug_unit.sv
module tb_debug_unit;
    localparam int NBITS = 32, RBITS = 5, BANK_SIZE = 32, MEM_SIZE = 1024;
    localparam int DUMP_BYTES = (2 + BANK_SIZE) * 4;
`ifdef DBG_CHECKSUM_EN
    localparam int CS_BYTES = 1;
`else
    localparam int CS_BYTES = 0;
`endif

    logic             i_clk, i_rst;
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             i_tx_done;
    logic             o_im_we;
    logic [NBITS-1:0] o_im_addr, o_im_data;
    logic             o_cpu_en, o_cpu_rst;
    logic             i_halt;
    logic [NBITS-1:0] i_pc;
    logic [RBITS-1:0] o_dbg_reg_addr;
    logic [NBITS-1:0] i_dbg_reg_data;

    debug_unit #(.NBITS(NBITS), .RBITS(RBITS), .BANK_SIZE(BANK_SIZE), .MEM_SIZE(MEM_SIZE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_im_we(o_im_we), .o_im_addr(o_im_addr), .o_im_data(o_im_data),
        .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst), .i_halt(i_halt), .i_pc(i_pc),
        .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register bank model: a distinct value for each index.
    function automatic logic [31:0] reg_val(input logic [RBITS-1:0] k);
        return 32'hA5C3_0F00 ^ ({{(32-RBITS){1'b0}}, k} * 32'h0101_0101);
    endfunction
    assign i_dbg_reg_data = reg_val(o_dbg_reg_addr);

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t        exp_wr_q[$];
    logic [7:0] exp_tx_q[$];
    wr_t        e_wr;
    logic [7:0] e_tx;

    int total = 0, passed = 0, errors = 0;
    int en_cnt = 0, rst_cnt = 0, tx_cnt = 0, we_cnt = 0;
    int we0, rst0, tx0, en0, run;
    logic [7:0]  cs;
    logic [31:0] d;
    logic [31:0] pc_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-memory writes, enable cycles and cpu reset pulses
    always @(negedge i_clk) begin
        if (o_cpu_en)  en_cnt++;
        if (o_cpu_rst) rst_cnt++;
        if (o_im_we) begin
            we_cnt++;
            chk("im_we_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                e_wr = exp_wr_q.pop_front();
                chk("im_addr", o_im_addr, e_wr.addr);
                chk("im_data", o_im_data, e_wr.data);
            end
        end
    end

    // Transmitter model: acknowledge two cycles after the request. Check the
    // byte at the acknowledge cycle, so that it has to stay stable until then.
    always begin
        @(negedge i_clk);
        if (o_tx_start) begin
            repeat (2) @(negedge i_clk);
            i_tx_done = 1'b1;
            tx_cnt++;
            chk("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) begin
                e_tx = exp_tx_q.pop_front();
                chk("tx_byte", 32'(o_tx_data), 32'(e_tx));
            end
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
        push_word(pc);
        push_word(cyc);
        for (int k = 0; k < BANK_SIZE; k++) push_word(reg_val(RBITS'(k)));
    endtask

    task automatic push_cs(input logic [7:0] c);
`ifdef DBG_CHECKSUM_EN
        exp_tx_q.push_back(c);
`else
        if (c === 8'hxx) exp_tx_q.push_back(c);
`endif
    endtask

    task automatic wait_rst(input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (rst_cnt >= target) break;
            @(negedge i_clk);
        end
        repeat (3) @(negedge i_clk);
        chk(tag, 32'(rst_cnt), 32'(target));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 5000; i++) begin
            if (exp_tx_q.size() == 0) break;
            @(negedge i_clk);
        end
        repeat (4) @(negedge i_clk);
        chk(tag, 32'(exp_tx_q.size()), 32'd0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_tx_data"},  32'(o_tx_data), 32'd0);
        chk({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "_im_we"},    32'(o_im_we), 32'd0);
        chk({tag, "_im_addr"},  o_im_addr, 32'd0);
        chk({tag, "_im_data"},  o_im_data, 32'd0);
        chk({tag, "_cpu_en"},   32'(o_cpu_en), 32'd0);
        chk({tag, "_cpu_rst"},  32'(o_cpu_rst), 32'd0);
        chk({tag, "_reg_addr"}, 32'(o_dbg_reg_addr), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_rx_data = '0; i_rx_valid = 1'b0; i_tx_done = 1'b0;
        i_halt = 1'b0; pc_v = 32'h0000_0040; i_pc = pc_v;
        repeat (3) @(negedge i_clk);
        chk_outs_zero("reset");
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // 1: two-word load
        we0 = we_cnt; rst0 = rst_cnt; tx0 = tx_cnt;
        exp_wr_q.push_back('{32'd0, 32'h2001_0005});
        exp_wr_q.push_back('{32'd1, 32'h0000_0000});
        push_cs(8'h24);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_word(32'h2001_0005); send_word(32'h0000_0000);
        wait_rst(rst0 + 1, "t1_cpu_rst");
        chk("t1_we_count", 32'(we_cnt - we0), 32'd2);
        chk("t1_tx_count", 32'(tx_cnt - tx0), 32'(CS_BYTES));
        chk("t1_wr_drained", 32'(exp_wr_q.size()), 32'd0);

        // 2: continuous run, halt after 7 enabled cycles
        pc_v = 32'h0000_1234; i_pc = pc_v;
        en0 = en_cnt; tx0 = tx_cnt; run = 0;
        push_dump(pc_v, 32'd7);
        send_byte(8'h43);
        for (int i = 0; i < 100 && run < 7; i++) begin
            @(negedge i_clk);
            if (o_cpu_en) run++;
        end
        i_halt = 1'b1;
        wait_drain("t2_dump_drain");
        chk("t2_en_cycles", 32'(en_cnt - en0), 32'd7);
        chk("t2_tx_count", 32'(tx_cnt - tx0), 32'(DUMP_BYTES));

        // N=0 load: clears the counter, pulses cpu reset, writes nothing
        we0 = we_cnt; rst0 = rst_cnt;
        push_cs(8'h00);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        wait_rst(rst0 + 1, "n0_cpu_rst");
        chk("n0_we_count", 32'(we_cnt - we0), 32'd0);

        // 3: two single steps
        i_halt = 1'b0; pc_v = 32'h0000_0100; i_pc = pc_v;
        en0 = en_cnt;
        push_dump(pc_v, 32'd1);
        send_byte(8'h53);
        wait_drain("t3_step1_drain");
        chk("t3_step1_en", 32'(en_cnt - en0), 32'd1);
        push_dump(pc_v, 32'd2);
        send_byte(8'h53);
        wait_drain("t3_step2_drain");
        chk("t3_step2_en", 32'(en_cnt - en0), 32'd2);

        // 5: junk bytes in IDLE, then a step while halted with bytes sent during the dump
        we0 = we_cnt; tx0 = tx_cnt; en0 = en_cnt;
        send_byte(8'h00); send_byte(8'h41);
        repeat (10) @(negedge i_clk);
        chk("t5_idle_en", 32'(en_cnt - en0), 32'd0);
        chk("t5_idle_tx", 32'(tx_cnt - tx0), 32'd0);
        chk("t5_idle_we", 32'(we_cnt - we0), 32'd0);
        i_halt = 1'b1;
        push_dump(pc_v, 32'd2);
        send_byte(8'h53);
        repeat (20) @(negedge i_clk);
        send_byte(8'h4C); send_byte(8'h43);
        wait_drain("t5_dump_drain");
        chk("t5_dump_tx", 32'(tx_cnt - tx0), 32'(DUMP_BYTES));
        chk("t5_halted_en", 32'(en_cnt - en0), 32'd0);

        // 4: MEM_SIZE+1 words, the last one wraps to address 0
        we0 = we_cnt; rst0 = rst_cnt; cs = 8'h00;
        for (int i = 0; i < MEM_SIZE + 1; i++) begin
            d = 32'h0BAD_0000 + i * 32'h0001_0003;
            exp_wr_q.push_back('{32'(i % MEM_SIZE), d});
            cs = cs ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        end
        push_cs(cs);
        send_byte(8'h4C); send_byte(8'h04); send_byte(8'h01);
        for (int i = 0; i < MEM_SIZE + 1; i++) send_word(32'h0BAD_0000 + i * 32'h0001_0003);
        wait_rst(rst0 + 1, "t4_cpu_rst");
        chk("t4_we_count", 32'(we_cnt - we0), 32'(MEM_SIZE + 1));
        chk("t4_wr_drained", 32'(exp_wr_q.size()), 32'd0);

        // 6: reset in the middle of a word; then a fresh load starts at address 0
        we0 = we_cnt; rst0 = rst_cnt;
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_outs_zero("midrst");
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("t6_no_we", 32'(we_cnt - we0), 32'd0);
        exp_wr_q.push_back('{32'd0, 32'hCAFE_F00D});
        push_cs(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01);
        send_word(32'hCAFE_F00D);
        wait_rst(rst0 + 1, "t6_cpu_rst");
        chk("t6_we_count", 32'(we_cnt - we0), 32'd1);
        chk("t6_wr_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
